pmem_responder: RTL and testbench
=================================

# pmem_responder

Synthesizable physical-memory responder for the cache-line memory port. It answers `pmem_read` and `pmem_write` requests from the L1/L2 hierarchy with a single-cycle `pmem_resp` pulse after a fixed, parameterized latency. It stores 128-bit lines in an internal array and replaces the behavioural memory model on the pmem side of `mp3`, for both FPGA builds and RTL regression.

## Interface
Parameters:
- `INDEX_BITS`, default 8: line-index width; the array holds 2^INDEX_BITS lines of 128 bits.
- `LATENCY`, default 4: cycles from request to response. Legal range is 1..15.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pmem_address`  in  16: byte address (`lc3b_word`). Bits [3:0] are ignored.
- `pmem_read`  in  1: read request, level, held until response.
- `pmem_write`  in  1: write request, level, held until response.
- `pmem_wdata`  in  128: write line (`lc3b_cache_line`).
- `pmem_resp`  out  1: one-cycle completion pulse.
- `pmem_rdata`  out  128: read line. Valid while `pmem_resp` is high; held otherwise.
- `pmem_error`  out  1: sticky protocol-violation flag (see Configuration).

## Operation
- Index is `pmem_address[4+INDEX_BITS-1:4]`. Address bits above the index alias to the same line.
- FSM states are IDLE, BUSY and RESP. Internal counter `cnt` is 4 bits wide.
- IDLE, no request: remain in IDLE.
- IDLE, request seen at an edge ("acceptance edge"):
  - Read: capture `array[index]` into the rdata staging register.
  - Write: write `pmem_wdata` into `array[index]`.
  - Go to RESP if `LATENCY`==1. Otherwise go to BUSY with `cnt`=`LATENCY`-2.
- BUSY: if `cnt`==0, go to RESP; else decrement `cnt`. Inputs are ignored, except by the checker.
- RESP: `pmem_resp`=1.
  - On a read, `pmem_rdata` presents the staged line during this cycle.
  - Return to IDLE at the next edge.
  - A request present in the IDLE cycle that follows is a new request. Back-to-back transactions therefore have a 1-cycle IDLE gap.
- Read and write both high at acceptance: treated as a write. `pmem_rdata` is unchanged.
- A write response leaves `pmem_rdata` unchanged. `pmem_rdata` only changes when a read response is issued.
- Requester obligations: hold `pmem_read`/`pmem_write`, `pmem_address` and `pmem_wdata` stable from the request cycle through the RESP cycle inclusive. The requester drops them in the cycle after RESP, or issues its next request there.
- Array contents are not cleared by reset and are undefined at power-up.

## Timing
- Request first high in cycle 0 gives `pmem_resp` high in cycle `LATENCY`, for exactly one cycle.
- The write is committed at the end of cycle 0. A read issued afterwards to the same line returns the new data.
- Reset values: `pmem_resp`=0, `pmem_rdata`=0, `pmem_error`=0, state=IDLE, `cnt`=0.
- Reset asserted mid-transaction aborts it and no response is issued. A write whose acceptance edge already occurred stays committed. Reset coincident with the acceptance edge wins, and nothing is written.
- `pmem_resp` and `pmem_rdata` are registered outputs, with no combinational path from any input.

## Configuration
- `PMEM_PROTOCOL_CHECK_EN` defined: the checker is compiled in. `pmem_error` sets, and stays set until `rst_n` is asserted, on any of:
  - read and write both high in IDLE;
  - during BUSY or RESP, the request dropped, its kind changed, or `pmem_address` changed;
  - during a write transaction, `pmem_wdata` changed.
- Not defined: no checker logic is built and `pmem_error` is tied to 0.
- Functional behaviour is identical either way.

## Test plan
- Reset, then write line 0x00112233445566778899AABBCCDDEEFF at address 0x0120 with `LATENCY`=4 -> `pmem_resp` pulses only in cycle 4. A subsequent read of 0x012C returns the same line in its resp cycle.
- `LATENCY`=1, back-to-back reads of 0x0000 and 0x0010 -> resp in cycles 1 and 3. `pmem_rdata` holds the first line through cycle 2.
- Alias check at `INDEX_BITS`=8: write 0xA…A to 0x0100, then read 0x1100 -> returns 0xA…A.
- Drop `rst_n` in cycle 2 of a read -> no resp is issued, `pmem_rdata`=0. After release, the FSM is in IDLE and a new read completes normally.
- With `PMEM_PROTOCOL_CHECK_EN`: change `pmem_address` from 0x0200 to 0x0210 during BUSY -> `pmem_error`=1 from the next cycle and it persists after resp. Without the macro, `pmem_error` stays 0.
- Read and write both high at 0x0300 with wdata 0x5…5 -> treated as a write. A later read returns 0x5…5 and `pmem_rdata` is unchanged at the write's resp.

Source files
------------

// File: rtl/pmem_responder.sv
// Fixed-latency cache-line memory responder for the pmem port.
// Optional protocol checker: define PMEM_PROTOCOL_CHECK_EN.
module pmem_responder #(
  parameter int INDEX_BITS = 8,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [127:0]          r_mem [2**INDEX_BITS];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_resp;
  logic [127:0]          r_rdata;
  logic [127:0]          r_stage;
  logic                  r_is_rd;

  logic [INDEX_BITS-1:0] w_idx;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_rd;

  assign w_idx    = pmem_address[4+INDEX_BITS-1:4];
  assign w_req    = pmem_read | pmem_write;
  assign w_accept = (r_state == ST_IDLE) && w_req;
  assign w_rd     = pmem_read & ~pmem_write;

  // Gated by rst_n so a reset landing on the acceptance edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && pmem_write) begin
      r_mem[w_idx] <= pmem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_stage <= '0;
      r_is_rd <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_is_rd <= w_rd;
            if (w_rd) begin
              r_stage <= r_mem[w_idx];
            end
            if (LATENCY == 1) begin
              r_state <= ST_RESP;
              r_resp  <= 1'b1;
              if (w_rd) begin
                r_rdata <= r_mem[w_idx];
              end
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_resp  <= 1'b1;
            if (r_is_rd) begin
              r_rdata <= r_stage;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pmem_resp  = r_resp;
  assign pmem_rdata = r_rdata;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic         r_error;
  logic [15:0]  r_addr;
  logic [127:0] r_wdata;
  logic [1:0]   r_kind;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_kind  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= pmem_address;
        r_wdata <= pmem_wdata;
        r_kind  <= {pmem_read, pmem_write};
      end
      if ((r_state == ST_IDLE) && pmem_read && pmem_write) begin
        r_error <= 1'b1;
      end
      // r_kind[0] marks a write transaction, whose data must also stay stable.
      if ((r_state != ST_IDLE) &&
          (({pmem_read, pmem_write} != r_kind) ||
           (pmem_address != r_addr) ||
           (r_kind[0] && (pmem_wdata != r_wdata)))) begin
        r_error <= 1'b1;
      end
    end
  end

  assign pmem_error = r_error;
`else
  logic w_unused;
  assign w_unused   = ^pmem_address;
  assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized self-checking bench for pmem_responder (LATENCY 4 and LATENCY 1 instances)
// against a line-array reference model.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd    [2];
  logic         wr    [2];
  logic [15:0]  addr  [2];
  logic [127:0] wd    [2];
  logic         resp  [2];
  logic [127:0] rdata [2];
  logic         err   [2];

  logic [127:0] mdl    [2][256];
  logic [127:0] exp_rd [2];
  int           lat    [2] = '{4, 1};
  int           checks   = 0;
  int           failures = 0;
  logic         exp_err;

  always #5 clk = ~clk;

  pmem_responder #(.INDEX_BITS(8), .LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pmem_address(addr[0]), .pmem_read(rd[0]),
    .pmem_write(wr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .pmem_error(err[0])
  );

  pmem_responder #(.INDEX_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_address(addr[1]), .pmem_read(rd[1]),
    .pmem_write(wr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .pmem_error(err[1])
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int s);
    rd[s] = 1'b0;
    wr[s] = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge (cycle 0); returns in the cycle after RESP with inputs dropped.
  task automatic txn(input int s, input bit r, input bit w, input logic [15:0] a,
                     input logic [127:0] d);
    int k;
    bit seen;
    rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d;
    if (w) mdl[s][a[11:4]] = d;
    else if (r) exp_rd[s] = mdl[s][a[11:4]];
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      step();
      k++;
      if (resp[s] === 1'b1) seen = 1'b1;
    end
    chk(s == 0 ? "resp_cycle_lat4" : "resp_cycle_lat1", k, lat[s]);
    chk("rdata_at_resp", rdata[s], exp_rd[s]);
    step();
    chk("resp_single_pulse", resp[s], 1'b0);
    chk("rdata_held", rdata[s], exp_rd[s]);
    drop(s);
  endtask

  initial begin
    logic [127:0] line;
    int s;
    bit r;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0; exp_rd[i] = '0;
    end
`ifdef PMEM_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("reset_resp", resp[i], 1'b0);
      chk("reset_rdata", rdata[i], '0);
      chk("reset_error", err[i], 1'b0);
    end
    rst_n = 1'b1;
    step();

    // Directed write then read of an offset within the same line.
    line = 128'h00112233445566778899AABBCCDDEEFF;
    txn(0, 1'b0, 1'b1, 16'h0120, line);
    txn(0, 1'b1, 1'b0, 16'h012C, '0);
    chk("write_read_same_line", rdata[0], line);

    // Fill every line of both arrays, back to back.
    for (int i = 0; i < 256; i++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 1'b0, 1'b1, {4'($urandom), 8'(i), 4'($urandom)}, line);
      line = {$urandom, $urandom, $urandom, $urandom};
      txn(1, 1'b0, 1'b1, {4'h0, 8'(i), 4'h0}, line);
    end

    // LATENCY=1 back-to-back reads; txn checks resp at cycle 1 and the hold in cycle 2.
    txn(1, 1'b1, 1'b0, 16'h0000, '0);
    chk("b2b_first_line", rdata[1], mdl[1][0]);
    txn(1, 1'b1, 1'b0, 16'h0010, '0);
    chk("b2b_second_line", rdata[1], mdl[1][1]);

    // Upper address bits alias onto the same line.
    line = {32{4'hA}};
    txn(0, 1'b0, 1'b1, 16'h0100, line);
    txn(0, 1'b1, 1'b0, 16'h1100, '0);
    chk("alias_read", rdata[0], line);

    repeat (80) begin
      s = int'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      line = {$urandom, $urandom, $urandom, $urandom};
      txn(s, r, !r, 16'($urandom), line);
      if ($urandom_range(0, 3) == 0) step();
    end
    chk("no_error_clean_traffic0", err[0], 1'b0);
    chk("no_error_clean_traffic1", err[1], 1'b0);

    // Read and write together behave as a write; rdata untouched at its resp.
    line = {32{4'h5}};
    txn(0, 1'b1, 1'b1, 16'h0300, line);
    txn(0, 1'b1, 1'b0, 16'h0300, '0);
    chk("rw_both_is_write", rdata[0], line);
    chk("rw_both_error", err[0], exp_err);

    // Reset in cycle 2 of a read aborts it.
    rd[0] = 1'b1; addr[0] = 16'h0120;
    step();
    step();
    rst_n = 1'b0;
    drop(0);
    #1;
    chk("abort_rdata", rdata[0], '0);
    chk("abort_error_cleared", err[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_resp", resp[0], 1'b0);
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst_n = 1'b1;
    step();
    txn(0, 1'b1, 1'b0, 16'h0120, '0);
    chk("read_after_abort", rdata[0], mdl[0][8'h12]);

    // Address changed during BUSY.
    exp_rd[0] = mdl[0][8'h20];
    rd[0] = 1'b1; addr[0] = 16'h0200;
    step();
    chk("pre_violation_error", err[0], 1'b0);
    step();
    addr[0] = 16'h0210;
    step();
    chk("addr_change_error", err[0], exp_err);
    step();
    chk("violation_resp", resp[0], 1'b1);
    chk("violation_rdata", rdata[0], exp_rd[0]);
    step();
    drop(0);
    step();
    chk("error_sticky", err[0], exp_err);
    chk("error_other_dut", err[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
